// File: rtl/ethernet_rx_port_arbiter.sv
// ethernet_rx_port_arbiter: round-robin arbiter sharing one L2 decoder among NUM_PORTS RX FIFOs.
// A grant covers exactly one frame. The granted port's bus is forwarded, registered, until
// commit or drop.
// Optional watchdog: define ETH_RX_ARB_TIMEOUT_EN to abort grants that stall for TIMEOUT_CYCLES.

package ethernet_rx_pkg;
   typedef struct packed {
      logic        start;
      logic        data_valid;
      logic [31:0] data;
      logic        commit;
      logic        drop;
   } EthernetRxBus;
endpackage

module ethernet_rx_port_arbiter
   import ethernet_rx_pkg::*;
#(
   parameter int unsigned NUM_PORTS      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                         sys_clk,
   input  logic                         rst_n,
   input  logic [NUM_PORTS-1:0]         port_frame_ready,
   input  EthernetRxBus                 port_rx_bus [NUM_PORTS],
   output logic [NUM_PORTS-1:0]         port_grant,
   output EthernetRxBus                 arb_rx_bus,
   output logic [$clog2(NUM_PORTS)-1:0] arb_port_id,
   output logic                         timeout_err
);

   localparam int unsigned PW = $clog2(NUM_PORTS);

   // Reject unsupported configurations at elaboration.
   if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536)
   begin : g_bad_params
      $error("ethernet_rx_port_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {StIdle, StGranted, StActive, StRelease} state_t;

   state_t            state_q;
   logic [PW-1:0]     gnt_idx_q;
   logic [PW-1:0]     rr_ptr_q;
   logic [PW-1:0]     pick_idx;
   logic [PW-1:0]     rr_next;
   logic              wdog_hit;
   EthernetRxBus      sel_bus;
   EthernetRxBus      start_bus;
   EthernetRxBus      fwd_bus;
   EthernetRxBus      drop_bus;

`ifdef ETH_RX_ARB_TIMEOUT_EN
   localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]       wdog_q;
`endif

   // First ready port at or after rr_ptr, wrapping to 0; lowest offset wins.
   always_comb begin
      int unsigned idx;
      pick_idx = '0;
      for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (port_frame_ready[PW'(idx)]) pick_idx = PW'(idx);
      end
   end

   // Granted-port bus views: start cycle, pass-through, and forced abort.
   always_comb begin
      sel_bus          = port_rx_bus[gnt_idx_q];
      start_bus        = sel_bus;
      start_bus.commit = 1'b0;
      start_bus.drop   = 1'b0;
      fwd_bus          = sel_bus;
      // Drop wins over commit when both arrive together.
      fwd_bus.commit   = sel_bus.commit & ~sel_bus.drop;
      drop_bus         = '0;
      drop_bus.drop    = 1'b1;
      rr_next          = (gnt_idx_q == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + 1'b1;
   end

   // Watchdog fires on the edge where the count reaches TIMEOUT_CYCLES-1.
   always_comb begin
`ifdef ETH_RX_ARB_TIMEOUT_EN
      wdog_hit = (state_q == StGranted || state_q == StActive) &&
                 ((wdog_q + 16'd1) == WdogLast);
`else
      wdog_hit = 1'b0;
`endif
   end

   // Arbitration FSM with registered outputs.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         gnt_idx_q   <= '0;
         rr_ptr_q    <= '0;
         port_grant  <= '0;
         arb_rx_bus  <= '0;
         arb_port_id <= '0;
         timeout_err <= 1'b0;
`ifdef ETH_RX_ARB_TIMEOUT_EN
         wdog_q      <= '0;
`endif
      end else begin
         timeout_err <= 1'b0;
         unique case (state_q)
            StIdle: begin
               arb_rx_bus <= '0;
               if (|port_frame_ready) begin
                  port_grant  <= NUM_PORTS'(1) << pick_idx;
                  gnt_idx_q   <= pick_idx;
                  arb_port_id <= pick_idx;
                  state_q     <= StGranted;
`ifdef ETH_RX_ARB_TIMEOUT_EN
                  wdog_q      <= '0;
`endif
               end
            end
            StGranted: begin
`ifdef ETH_RX_ARB_TIMEOUT_EN
               wdog_q <= wdog_q + 16'd1;
`endif
               if (wdog_hit) begin
                  arb_rx_bus  <= '0;
                  timeout_err <= 1'b1;
                  port_grant  <= '0;
                  rr_ptr_q    <= rr_next;
                  state_q     <= StRelease;
               end else if (sel_bus.start) begin
                  arb_rx_bus <= start_bus;
                  state_q    <= StActive;
               end else begin
                  // Anything the port sends before start is not part of a frame.
                  arb_rx_bus <= '0;
               end
            end
            StActive: begin
`ifdef ETH_RX_ARB_TIMEOUT_EN
               wdog_q <= wdog_q + 16'd1;
`endif
               if (wdog_hit || sel_bus.start) begin
                  // Stall or restarted frame: abort the one in flight.
                  arb_rx_bus  <= drop_bus;
                  timeout_err <= wdog_hit;
                  port_grant  <= '0;
                  rr_ptr_q    <= rr_next;
                  state_q     <= StRelease;
               end else if (sel_bus.commit || sel_bus.drop) begin
                  arb_rx_bus <= fwd_bus;
                  port_grant <= '0;
                  rr_ptr_q   <= rr_next;
                  state_q    <= StRelease;
               end else begin
                  arb_rx_bus <= sel_bus;
               end
            end
            StRelease: begin
               arb_rx_bus <= '0;
               state_q    <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ethernet_rx_port_arbiter.sv
// Directed testbench for ethernet_rx_port_arbiter (NUM_PORTS=4, TIMEOUT_CYCLES=64).
// Watchdog checks follow ETH_RX_ARB_TIMEOUT_EN.

module tb_ethernet_rx_port_arbiter;
   import ethernet_rx_pkg::*;

   localparam int unsigned NP = 4;

   logic           sys_clk = 1'b0;
   logic           rst_n;
   logic [NP-1:0]  ready;
   EthernetRxBus   pbus [NP];
   logic [NP-1:0]  grant;
   EthernetRxBus   arb;
   logic [1:0]     pid;
   logic           tout;

   int n_checks = 0;
   int n_fail   = 0;

   ethernet_rx_port_arbiter #(
      .NUM_PORTS      (NP),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .sys_clk          (sys_clk),
      .rst_n            (rst_n),
      .port_frame_ready (ready),
      .port_rx_bus      (pbus),
      .port_grant       (grant),
      .arb_rx_bus       (arb),
      .arb_port_id      (pid),
      .timeout_err      (tout)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic EthernetRxBus mk(input logic s, input logic dv, input logic [31:0] d,
                                       input logic c, input logic dr);
      EthernetRxBus b;
      b.start      = s;
      b.data_valid = dv;
      b.data       = d;
      b.commit     = c;
      b.drop       = dr;
      return b;
   endfunction

   initial begin
      logic held;
      int   p;

      rst_n = 1'b0;
      ready = '0;
      for (int i = 0; i < NP; i++) pbus[i] = '0;
      repeat (3) tick;
      chk("reset_grant", 64'(grant), 64'd0);
      chk("reset_bus", 64'(arb), 64'd0);
      chk("reset_id", 64'(pid), 64'd0);
      chk("reset_tout", 64'(tout), 64'd0);
      rst_n = 1'b1;

      // Ports 0 and 2 ready; ungranted port 3 chatters throughout port 0's frame.
      ready   = 4'b0101;
      pbus[3] = mk(1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b0);
      tick;
      chk("t1_grant0", 64'(grant), 64'b0001);
      chk("t1_id0", 64'(pid), 64'd0);
      chk("t1_bus_pre", 64'(arb), 64'd0);
      pbus[0] = mk(1'b1, 1'b1, 32'h11110000, 1'b0, 1'b0);
      tick;
      chk("t1_w0", 64'(arb), 64'(mk(1'b1, 1'b1, 32'h11110000, 1'b0, 1'b0)));
      pbus[0] = mk(1'b0, 1'b1, 32'h11110001, 1'b0, 1'b0);
      tick;
      chk("t1_w1", 64'(arb), 64'(mk(1'b0, 1'b1, 32'h11110001, 1'b0, 1'b0)));
      pbus[0] = mk(1'b0, 1'b1, 32'h11110002, 1'b0, 1'b0);
      tick;
      chk("t1_w2", 64'(arb), 64'(mk(1'b0, 1'b1, 32'h11110002, 1'b0, 1'b0)));
      pbus[0] = mk(1'b0, 1'b1, 32'h11110003, 1'b1, 1'b0);
      tick;
      chk("t1_w3_commit", 64'(arb), 64'(mk(1'b0, 1'b1, 32'h11110003, 1'b1, 1'b0)));
      chk("t1_grant_clr", 64'(grant), 64'd0);
      chk("t1_id_hold", 64'(pid), 64'd0);
      pbus[0] = '0;
      pbus[3] = '0;
      ready   = 4'b0100;
      tick;
      chk("t1_release_bus", 64'(arb), 64'd0);
      chk("t1_release_grant", 64'(grant), 64'd0);
      tick;
      chk("t1_grant2", 64'(grant), 64'b0100);
      chk("t1_id2", 64'(pid), 64'd2);
      pbus[2] = mk(1'b0, 1'b1, 32'h0000DEAD, 1'b1, 1'b0);
      tick;
      chk("t1_pre_start_ignored", 64'(arb), 64'd0);
      chk("t1_grant2_held", 64'(grant), 64'b0100);
      pbus[2] = mk(1'b1, 1'b1, 32'h22220000, 1'b0, 1'b0);
      tick;
      chk("t1_p2_start", 64'(arb), 64'(mk(1'b1, 1'b1, 32'h22220000, 1'b0, 1'b0)));
      pbus[2] = mk(1'b0, 1'b1, 32'h22220001, 1'b1, 1'b0);
      tick;
      chk("t1_p2_commit", 64'(arb), 64'(mk(1'b0, 1'b1, 32'h22220001, 1'b1, 1'b0)));
      pbus[2] = '0;
      ready   = '0;
      tick;
      tick;
      chk("t1_idle_grant", 64'(grant), 64'd0);

      // Port 1: commit and drop together, then rr_ptr must sit at 2.
      ready = 4'b0010;
      tick;
      chk("t3_grant1", 64'(grant), 64'b0010);
      chk("t3_id1", 64'(pid), 64'd1);
      pbus[1] = mk(1'b1, 1'b1, 32'h33330000, 1'b0, 1'b0);
      tick;
      chk("t3_start", 64'(arb), 64'(mk(1'b1, 1'b1, 32'h33330000, 1'b0, 1'b0)));
      pbus[1] = mk(1'b0, 1'b1, 32'h33330001, 1'b1, 1'b1);
      tick;
      chk("t3_drop_only", 64'(arb), 64'(mk(1'b0, 1'b1, 32'h33330001, 1'b0, 1'b1)));
      chk("t3_grant_clr", 64'(grant), 64'd0);
      pbus[1] = '0;
      ready   = 4'b1111;
      tick;
      chk("t3_release_bus", 64'(arb), 64'd0);
      tick;
      chk("t3_rr_at_2", 64'(grant), 64'b0100);

      // Reset pulsed mid-frame on port 2.
      pbus[2] = mk(1'b1, 1'b1, 32'h66660000, 1'b0, 1'b0);
      tick;
      chk("t6_start", 64'(arb), 64'(mk(1'b1, 1'b1, 32'h66660000, 1'b0, 1'b0)));
      pbus[2] = mk(1'b0, 1'b1, 32'h66660001, 1'b0, 1'b0);
      tick;
      chk("t6_mid", 64'(arb), 64'(mk(1'b0, 1'b1, 32'h66660001, 1'b0, 1'b0)));
      rst_n = 1'b0;
      #1;
      chk("t6_async_grant", 64'(grant), 64'd0);
      chk("t6_async_bus", 64'(arb), 64'd0);
      chk("t6_async_id", 64'(pid), 64'd0);
      tick;
      rst_n   = 1'b1;
      pbus[2] = '0;
      tick;
      chk("t6_port0_wins", 64'(grant), 64'b0001);

      // All ports ready: eight frames, strict rotation with idle gaps.
      for (int k = 0; k < 8; k++) begin
         p = k % 4;
         chk("t2_grant", 64'(grant), 64'(1) << p);
         chk("t2_id", 64'(pid), 64'(p));
         pbus[p] = mk(1'b1, 1'b1, 32'(k), 1'b0, 1'b0);
         tick;
         chk("t2_start", 64'(arb), 64'(mk(1'b1, 1'b1, 32'(k), 1'b0, 1'b0)));
         chk("t2_onehot", 64'($onehot0(grant)), 64'd1);
         pbus[p] = mk(1'b0, 1'b1, 32'(k) + 32'd100, 1'b1, 1'b0);
         tick;
         chk("t2_commit", 64'(arb), 64'(mk(1'b0, 1'b1, 32'(k) + 32'd100, 1'b1, 1'b0)));
         chk("t2_grant_clr", 64'(grant), 64'd0);
         pbus[p] = '0;
         tick;
         chk("t2_gap_grant", 64'(grant), 64'd0);
         chk("t2_gap_bus", 64'(arb), 64'd0);
         tick;
      end

      // Port 0 is granted again here and never starts.
      ready = 4'b0011;
`ifdef ETH_RX_ARB_TIMEOUT_EN
      repeat (62) tick;
      chk("t5_grant_held", 64'(grant), 64'b0001);
      chk("t5_no_tout_yet", 64'(tout), 64'd0);
      tick;
      chk("t5_tout_pulse", 64'(tout), 64'd1);
      chk("t5_grant_clr", 64'(grant), 64'd0);
      chk("t5_bus_quiet", 64'(arb), 64'd0);
      tick;
      chk("t5_tout_end", 64'(tout), 64'd0);
      tick;
      chk("t5_next_port1", 64'(grant), 64'b0010);
      chk("t5_next_id", 64'(pid), 64'd1);
`else
      held = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         tick;
         if (grant !== 4'b0001 || tout !== 1'b0) held = 1'b0;
      end
      chk("t5_grant_held_forever", 64'(held), 64'd1);
      chk("t5_tout_tied", 64'(tout), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
